// File: rtl/apu_pkg.sv
// Shared APU definitions: triangle register indices, triangle mode encoding and
// the length-counter load table used by every voice.
package apu_pkg;

    localparam logic [1:0] APU_TRI_R0 = 2'd0;
    localparam logic [1:0] APU_TRI_R1 = 2'd1;
    localparam logic [1:0] APU_TRI_R2 = 2'd2;
    localparam logic [1:0] APU_TRI_R3 = 2'd3;

    typedef enum logic {
        TRI_MODE_TRIANGLE = 1'b0,
        TRI_MODE_SAW      = 1'b1
    } tri_mode_e;

    localparam logic [7:0] APU_LENGTH_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/apu_length_lut.sv
// Combinational 5-bit length index to 8-bit length-counter load value.
module apu_length_lut
    import apu_pkg::*;
(
    input  logic [4:0] i_index,
    output logic [7:0] o_length
);

    assign o_length = APU_LENGTH_TABLE[i_index];

endmodule

// File: rtl/apu_triangle_gen.sv
// Triangle/sawtooth voice: period timer, linear and length counters gate a
// step sequencer whose value is shaped into a registered sample.
module apu_triangle_gen
    import apu_pkg::*;
#(
    parameter int TIMER_W = 11,
    parameter int LIN_W   = 7,
    parameter int OUT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             qframe,
    input  logic             hframe,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [7:0]       wdata,
    output logic             act,
    output logic [OUT_W-1:0] out
);

    localparam int STEP_W = OUT_W + 1;
    localparam int HI_W   = TIMER_W - 8;

    logic               r_ctrl;
    logic [LIN_W-1:0]   r_lin_reload;
    tri_mode_e          r_mode;
    logic               r_umute;
    logic [TIMER_W-1:0] r_period;
    logic [TIMER_W-1:0] r_timer;
    logic               r_tick;
    logic [LIN_W-1:0]   r_linear;
    logic               r_reload_flag;
    logic [7:0]         r_length;
    logic [STEP_W-1:0]  r_step;
    logic [OUT_W-1:0]   r_out;

    logic               w_wr;
    logic               w_wr_r3;
    logic               w_clear;
    logic [TIMER_W-1:0] w_period_r3;
    logic [7:0]         w_lut_length;
    logic               w_muted;
    logic               w_step_en;
    logic [OUT_W-1:0]   w_sample;

    assign w_wr        = en && sel && we;
    assign w_wr_r3     = w_wr && (addr == APU_TRI_R3);
    assign w_clear     = reset || !en;
    assign w_period_r3 = {wdata[HI_W-1:0], r_period[7:0]};

    apu_length_lut u_length_lut (
        .i_index  (wdata[7:3]),
        .o_length (w_lut_length)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_ctrl       <= 1'b0;
            r_lin_reload <= '0;
            r_mode       <= TRI_MODE_TRIANGLE;
            r_umute      <= 1'b0;
            r_period     <= '0;
        end else if (w_wr) begin
            case (addr)
                APU_TRI_R0: begin
                    r_ctrl       <= wdata[7];
                    r_lin_reload <= wdata[LIN_W-1:0];
                end
                APU_TRI_R1: begin
                    r_mode  <= tri_mode_e'(wdata[0]);
                    r_umute <= wdata[1];
                end
                APU_TRI_R2: r_period[7:0]         <= wdata;
                APU_TRI_R3: r_period[TIMER_W-1:8] <= wdata[HI_W-1:0];
                default: ;
            endcase
        end
    end

    // An R3 write restarts the timer with the period it just wrote.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_timer <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= (r_timer == '0);
            if (w_wr_r3)
                r_timer <= w_period_r3;
            else if (r_timer == '0)
                r_timer <= r_period;
            else
                r_timer <= r_timer - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_linear      <= '0;
            r_reload_flag <= 1'b0;
        end else begin
            if (qframe) begin
                if (r_reload_flag)
                    r_linear <= r_lin_reload;
                else if (r_linear != '0)
                    r_linear <= r_linear - LIN_W'(1);
            end
            if (w_wr_r3)
                r_reload_flag <= 1'b1;
            else if (qframe && !r_ctrl)
                r_reload_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear)
            r_length <= '0;
        else if (w_wr_r3)
            r_length <= w_lut_length;
        else if (hframe && !r_ctrl && (r_length != '0))
            r_length <= r_length - 8'd1;
    end

    // Periods below 2 are ultrasonic; umute freezes the sequencer there.
    assign w_muted   = r_umute && (r_period < TIMER_W'(2));
    assign w_step_en = r_tick && (r_linear != '0) && (r_length != '0) && !w_muted;

    always_ff @(posedge clk) begin
        if (w_clear)
            r_step <= '0;
        else if (w_step_en)
            r_step <= r_step + STEP_W'(1);
    end

    always_comb begin
        w_sample = '0;
        if (r_mode == TRI_MODE_SAW)
            w_sample = r_step[OUT_W:1];
        else
            w_sample = {OUT_W{r_step[OUT_W]}} ^ r_step[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (w_clear)
            r_out <= '0;
        else
            r_out <= w_sample;
    end

    assign act = (r_length != '0);
    assign out = r_out;

endmodule

// File: tb/tb_apu_triangle_gen.sv
// Self-checking bench for apu_triangle_gen: length table vectors plus
// multi-cycle sequences for the sequencer, gating and coincident events.
module tb_apu_triangle_gen;

    localparam int OUT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             qframe;
    logic             hframe;
    logic             sel;
    logic             we;
    logic [1:0]       addr;
    logic [7:0]       wdata;
    logic             act;
    logic [OUT_W-1:0] out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [OUT_W-1:0] exp_q[$];

    typedef struct {
        logic [4:0] idx;
        int         len;
    } lut_vec_t;

    lut_vec_t lut_tab[10];

    apu_triangle_gen #(
        .TIMER_W (11),
        .LIN_W   (7),
        .OUT_W   (OUT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .qframe (qframe),
        .hframe (hframe),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .act    (act),
        .out    (out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got == expv)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    task automatic wr_ev(input logic [1:0] a, input logic [7:0] d, input logic qf, input logic hf);
        sel    = 1'b1;
        we     = 1'b1;
        addr   = a;
        wdata  = d;
        qframe = qf;
        hframe = hf;
        step_clk();
        sel    = 1'b0;
        we     = 1'b0;
        qframe = 1'b0;
        hframe = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_ev(a, d, 1'b0, 1'b0);
    endtask

    task automatic pulse_q();
        qframe = 1'b1;
        step_clk();
        qframe = 1'b0;
    endtask

    task automatic pulse_h();
        hframe = 1'b1;
        step_clk();
        hframe = 1'b0;
    endtask

    task automatic clear_channel();
        en = 1'b0;
        step_clk();
        step_clk();
        en = 1'b1;
    endtask

    task automatic wait_out(input logic [OUT_W-1:0] target, input string name);
        int i;
        i = 0;
        while (out !== target && i < 64) begin
            step_clk();
            i++;
        end
        check(name, int'(out), int'(target));
    endtask

    function automatic logic [OUT_W-1:0] tri_val(input int k);
        int s;
        s = k % 32;
        return (s < 16) ? OUT_W'(s) : OUT_W'(31 - s);
    endfunction

    function automatic logic [OUT_W-1:0] saw_val(input int k);
        return OUT_W'((k % 32) / 2);
    endfunction

    // Called on the cycle out first shows step k0; each step lasts 'hold' clocks.
    task automatic run_seq(input string name, input int k0, input int k1, input int hold, input bit saw);
        for (int k = k0; k <= k1; k++)
            exp_q.push_back(saw ? saw_val(k) : tri_val(k));
        while (exp_q.size() > 0) begin
            logic [OUT_W-1:0] e;
            e = exp_q.pop_front();
            check({name, "_lead"}, int'(out), int'(e));
            repeat (hold - 1) step_clk();
            check({name, "_tail"}, int'(out), int'(e));
            step_clk();
        end
    endtask

    task automatic check_frozen(input string name);
        logic [OUT_W-1:0] hold_v;
        step_clk();
        hold_v = out;
        for (int i = 0; i < 5; i++) begin
            repeat (4) step_clk();
            check(name, int'(out), int'(hold_v));
        end
    endtask

    task automatic setup_tri(input logic [7:0] period);
        wr(2'd0, 8'h05);
        wr(2'd2, period);
        wr(2'd3, 8'h08);
    endtask

    initial begin
        lut_tab[0] = '{5'd0,  10};
        lut_tab[1] = '{5'd3,  2};
        lut_tab[2] = '{5'd5,  4};
        lut_tab[3] = '{5'd7,  6};
        lut_tab[4] = '{5'd11, 10};
        lut_tab[5] = '{5'd13, 12};
        lut_tab[6] = '{5'd16, 12};
        lut_tab[7] = '{5'd17, 16};
        lut_tab[8] = '{5'd29, 28};
        lut_tab[9] = '{5'd31, 30};

        reset = 1'b1; en = 1'b0; qframe = 1'b0; hframe = 1'b0;
        sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'd0;
        repeat (3) step_clk();
        check("reset_act", int'(act), 0);
        check("reset_out", int'(out), 0);
        reset = 1'b0;
        en = 1'b1;
        step_clk();

        // Triangle at period 3: one step every 4 clocks.
        setup_tri(8'd3);
        check("act_after_r3", int'(act), 1);
        pulse_q();
        wait_out(4'd1, "tri_start");
        run_seq("tri", 1, 40, 4, 1'b0);

        // Reset lands on the edge where the pending tick would advance step.
        step_clk();
        step_clk();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        check("midreset_act", int'(act), 0);
        check("midreset_out", int'(out), 0);
        repeat (5) step_clk();
        check("postreset_act", int'(act), 0);
        check("postreset_out", int'(out), 0);

        // Linear counter expiry.
        clear_channel();
        wr(2'd0, 8'h02);
        wr(2'd2, 8'd3);
        wr(2'd3, 8'h08);
        pulse_q();
        wait_out(4'd1, "lin_start");
        pulse_q();
        pulse_q();
        check_frozen("lin_frozen");

        // Length halt, then decrement to zero.
        clear_channel();
        wr(2'd0, 8'h85);
        wr(2'd2, 8'd3);
        wr(2'd3, 8'h08);
        pulse_q();
        repeat (10) pulse_h();
        check("len_halt", int'(act), 1);
        wr(2'd0, 8'h05);
        repeat (253) pulse_h();
        check("len_253", int'(act), 1);
        pulse_h();
        check("len_zero", int'(act), 0);
        check_frozen("len_frozen");

        // Length table vectors.
        for (int v = 0; v < 10; v++) begin
            clear_channel();
            wr(2'd0, 8'h00);
            wr(2'd3, {lut_tab[v].idx, 3'b000});
            check("lut_load_act", int'(act), 1);
            repeat (lut_tab[v].len - 1) pulse_h();
            check("lut_last_act", int'(act), 1);
            pulse_h();
            check("lut_empty_act", int'(act), 0);
        end

        // Sawtooth.
        clear_channel();
        wr(2'd1, 8'h01);
        setup_tri(8'd3);
        pulse_q();
        wait_out(4'd1, "saw_start");
        run_seq("saw", 2, 40, 4, 1'b1);

        // Ultrasonic mute at period 1, then the same period unmuted.
        clear_channel();
        wr(2'd1, 8'h02);
        setup_tri(8'd1);
        pulse_q();
        for (int i = 0; i < 6; i++) begin
            repeat (5) step_clk();
            check("umute_out", int'(out), 0);
        end
        clear_channel();
        setup_tri(8'd1);
        pulse_q();
        wait_out(4'd1, "p1_start");
        run_seq("p1", 1, 12, 2, 1'b0);

        // R3 write coinciding with hframe: load wins.
        clear_channel();
        wr(2'd0, 8'h00);
        wr_ev(2'd3, {5'd3, 3'b000}, 1'b0, 1'b1);
        check("r3h_act", int'(act), 1);
        pulse_h();
        check("r3h_one_left", int'(act), 1);
        pulse_h();
        check("r3h_empty", int'(act), 0);

        // R3 write coinciding with qframe: flag survives for the next qframe.
        clear_channel();
        wr(2'd0, 8'h05);
        wr(2'd2, 8'd3);
        wr_ev(2'd3, 8'h08, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (5) step_clk();
            check("r3q_idle", int'(out), 0);
        end
        pulse_q();
        wait_out(4'd1, "r3q_load");

        // Disable mid-run, writes while disabled, registers cleared.
        clear_channel();
        setup_tri(8'd3);
        pulse_q();
        wait_out(4'd1, "dis_start");
        repeat (10) step_clk();
        en = 1'b0;
        step_clk();
        check("dis_out", int'(out), 0);
        check("dis_act", int'(act), 0);
        wr(2'd0, 8'h05);
        wr(2'd3, 8'h08);
        check("dis_wr_ignored", int'(act), 0);
        en = 1'b1;
        repeat (3) step_clk();
        check("reen_act", int'(act), 0);
        check("reen_out", int'(out), 0);
        wr(2'd3, 8'h08);
        check("reen_r3_act", int'(act), 1);
        pulse_q();
        for (int i = 0; i < 5; i++) begin
            repeat (4) step_clk();
            check("r0_cleared_out", int'(out), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
